// File: rtl/lsu_dbus_ctrl_pkg.sv
// rtl/lsu_dbus_ctrl_pkg.sv - shared encodings, defaults and bus structs for the load/store unit
package lsu_dbus_ctrl_pkg;

    localparam int XLEN = 32;

    // Default DMEM window and ack timeout
    localparam logic [XLEN-1:0] DMEM_BASE_DEF      = 32'h0000_0000;
    localparam logic [XLEN-1:0] DMEM_SIZE_DEF      = 32'h0000_4000;
    localparam int              TIMEOUT_CYCLES_DEF = 16;

    // Access size encoding
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Fault cause encoding (00 means no fault)
    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_DECODE   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    // Transaction FSM states
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    typedef struct packed {
        logic            req;
        logic            w_en;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] w_data;
        logic [3:0]      sel_byte;
    } type_dbus2peri_s;

    typedef struct packed {
        logic [XLEN-1:0] r_data;
        logic            ack;
    } type_peri2dbus_s;

    // Natural alignment check; size 11 is never legal
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SZ_ILL)
            || ((size == SZ_HALF) && addr_lo[0])
            || ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - byte-lane select, store replication and load lane extract/extend
module lsu_data_align
    import lsu_dbus_ctrl_pkg::*;
(
    input  logic [1:0]      i_size,
    input  logic [1:0]      i_addr_lo,
    input  logic            i_unsigned,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_sel_byte,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Lane enables, replicated store data and extended load data per access size
    always_comb begin
        o_sel_byte = 4'b1111;
        o_wdata    = i_wdata;
        o_rdata    = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                o_sel_byte = 4'b0001 << i_addr_lo;
                o_wdata    = {4{i_wdata[7:0]}};
                o_rdata    = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_sel_byte = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {{16{~i_unsigned & w_half[15]}}, w_half};
            end
            default: begin
                o_sel_byte = 4'b1111;
                o_wdata    = i_wdata;
                o_rdata    = i_rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_dbus_ctrl.sv
// rtl/lsu_dbus_ctrl.sv - load/store unit driving single-cycle dbus requests with fault reporting
module lsu_dbus_ctrl
    import lsu_dbus_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] DMEM_BASE      = DMEM_BASE_DEF,
    parameter logic [XLEN-1:0] DMEM_SIZE      = DMEM_SIZE_DEF,
    parameter int              TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lsu_req_i,
    input  logic            lsu_we_i,
    input  logic [1:0]      lsu_size_i,
    input  logic            lsu_unsigned_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    input  logic            lsu_kill_i,
    output logic            lsu_stall_o,
    output logic            lsu_valid_o,
    output logic [XLEN-1:0] lsu_rdata_o,
    output logic            lsu_exc_o,
    output logic [1:0]      lsu_cause_o,
    output logic            dmem_sel_o,
    output type_dbus2peri_s lsu2mem_o,
    input  type_peri2dbus_s mem2lsu_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic            r_we;
    logic            r_unsigned;
    logic            r_kill;
    logic [1:0]      r_size;
    logic [1:0]      r_cause;
    logic [CNT_W-1:0] r_cnt;

    logic            w_accept;
    logic            w_misalign;
    logic            w_hit;
    logic            w_timeout;
    logic            w_killed;
    logic            w_issue;
    logic [XLEN-1:0] w_off;
    logic [3:0]      w_sel_byte;
    logic [XLEN-1:0] w_bus_wdata;
    logic [XLEN-1:0] w_load_data;

    // A flush in the same cycle as the request means it never gets accepted
    assign w_accept   = (r_state == ST_IDLE) && lsu_req_i && !lsu_kill_i;
    assign w_misalign = is_misaligned(lsu_size_i, lsu_addr_i[1:0]);
    // Offset compare also rejects addresses below the base through wrap-around
    assign w_off      = lsu_addr_i - DMEM_BASE;
    assign w_hit      = (w_off < DMEM_SIZE);
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_killed   = r_kill || lsu_kill_i;
    // A kill during ISSUE suppresses the bus strobe so a store never lands
    assign w_issue    = (r_state == ST_ISSUE) && !lsu_kill_i;

    lsu_data_align u_align (
        .i_size     (r_size),
        .i_addr_lo  (r_addr[1:0]),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rdata    (mem2lsu_i.r_data),
        .o_sel_byte (w_sel_byte),
        .o_wdata    (w_bus_wdata),
        .o_rdata    (w_load_data)
    );

    // Next-state decode for the IDLE/ISSUE/WAIT/DONE transaction sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_misalign || !w_hit) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = lsu_kill_i ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (mem2lsu_i.ack || w_timeout) begin
                    w_state_nxt = w_killed ? ST_IDLE : ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transaction context, timeout counter, sticky kill and completion result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_kill     <= 1'b0;
            r_size     <= SZ_BYTE;
            r_cause    <= CAUSE_NONE;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= lsu_addr_i;
                        r_wdata    <= lsu_wdata_i;
                        r_we       <= lsu_we_i;
                        r_unsigned <= lsu_unsigned_i;
                        r_size     <= lsu_size_i;
                        r_kill     <= 1'b0;
                        if (w_misalign) begin
                            r_cause <= CAUSE_MISALIGN;
                            r_rdata <= '0;
                        end else if (!w_hit) begin
                            r_cause <= CAUSE_DECODE;
                            r_rdata <= '0;
                        end else begin
                            r_cause <= CAUSE_NONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= '0;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (lsu_kill_i) begin
                        r_kill <= 1'b1;
                    end
                    if (mem2lsu_i.ack) begin
                        if (!w_killed) begin
                            r_rdata <= r_we ? '0 : w_load_data;
                            r_cause <= CAUSE_NONE;
                        end
                    end else if (w_timeout && !w_killed) begin
                        r_rdata <= '0;
                        r_cause <= CAUSE_TIMEOUT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus request is a pure decode of ISSUE so reset drops it immediately
    always_comb begin
        lsu2mem_o = '0;
        if (w_issue) begin
            lsu2mem_o.req      = 1'b1;
            lsu2mem_o.w_en     = r_we;
            lsu2mem_o.addr     = r_addr;
            lsu2mem_o.w_data   = w_bus_wdata;
            lsu2mem_o.sel_byte = w_sel_byte;
        end
    end

    assign dmem_sel_o  = w_issue;
    assign lsu_stall_o = rst_n && (((r_state == ST_IDLE) && lsu_req_i)
                                   || (r_state == ST_ISSUE) || (r_state == ST_WAIT));
    assign lsu_valid_o = (r_state == ST_DONE) && (r_cause == CAUSE_NONE);
    assign lsu_exc_o   = (r_state == ST_DONE) && (r_cause != CAUSE_NONE);
    assign lsu_cause_o = (r_state == ST_DONE) ? r_cause : CAUSE_NONE;
    assign lsu_rdata_o = r_rdata;

endmodule
